// File: rtl/alu_sequencer_pkg.sv
// Shared ALU definitions: opcodes, flag indices and sequencer state encoding.
package alu_sequencer_pkg;

  localparam int ALU_FLAG_COUNT    = 4;
  localparam int ALU_FLAG_ZERO     = 0;
  localparam int ALU_FLAG_OVERFLOW = 1;
  localparam int ALU_FLAG_NEGATIVE = 2;
  localparam int ALU_FLAG_EQUAL    = 3;

  localparam logic [7:0] ALU_ADD = 8'h01;
  localparam logic [7:0] ALU_EQ  = 8'h02;
  localparam logic [7:0] ALU_SUB = 8'h03;
  localparam logic [7:0] ALU_OR  = 8'h04;
  localparam logic [7:0] ALU_AND = 8'h05;
  localparam logic [7:0] ALU_XOR = 8'h06;
  localparam logic [7:0] ALU_NEG = 8'h07;

  typedef enum logic [1:0] {
    ALU_SEQ_IDLE = 2'd0,
    ALU_SEQ_EXEC = 2'd1,
    ALU_SEQ_RESP = 2'd2
  } alu_seq_state_t;

endpackage

// File: rtl/alu_sequencer_alu.sv
// Combinational ALU; OVERFLOW carries the carry-out of ADD and the borrow of SUB.
module alu_sequencer_alu
  import alu_sequencer_pkg::*;
#(
  parameter int BUS_SIZE = 32
) (
  input  logic [7:0]                i_op,
  input  logic [BUS_SIZE-1:0]       i_a,
  input  logic [BUS_SIZE-1:0]       i_b,
  input  logic                      i_carry_in,
  output logic [BUS_SIZE-1:0]       o_res,
  output logic [ALU_FLAG_COUNT-1:0] o_flags
);

  logic [BUS_SIZE-1:0] w_res;
  logic                w_ovf;
  logic                w_eq;

  assign w_eq = (i_a == i_b);

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (i_op)
      ALU_ADD: {w_ovf, w_res} = {1'b0, i_a} + {1'b0, i_b} + {{BUS_SIZE{1'b0}}, i_carry_in};
      ALU_SUB: {w_ovf, w_res} = {1'b0, i_a} - {1'b0, i_b} - {{BUS_SIZE{1'b0}}, i_carry_in};
      ALU_EQ:  w_res = {{(BUS_SIZE-1){1'b0}}, w_eq};
      ALU_OR:  w_res = i_a | i_b;
      ALU_AND: w_res = i_a & i_b;
      ALU_XOR: w_res = i_a ^ i_b;
      ALU_NEG: w_res = '0 - i_a;
      default: w_res = '0;
    endcase
  end

  always_comb begin
    o_flags                    = '0;
    o_flags[ALU_FLAG_ZERO]     = (w_res == '0);
    o_flags[ALU_FLAG_OVERFLOW] = w_ovf;
    o_flags[ALU_FLAG_NEGATIVE] = w_res[BUS_SIZE-1];
    o_flags[ALU_FLAG_EQUAL]    = w_eq;
  end

  assign o_res = w_res;

endmodule

// File: rtl/alu_sequencer.sv
// Request/response wrapper around the ALU with a persistent status-flag register.
// state | meaning
// IDLE  | waiting for a request, req_ready=1
// EXEC  | operands registered, ALU settling
// RESP  | response held until rsp handshake; may accept next request same edge
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int BUS_SIZE  = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [7:0]                req_op,
  input  logic [BUS_SIZE-1:0]       req_a,
  input  logic [BUS_SIZE-1:0]       req_b,
  input  logic                      req_setflags,
  input  logic                      req_usecarry,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [BUS_SIZE-1:0]       rsp_res,
  output logic [ALU_FLAG_COUNT-1:0] rsp_flags,
  output logic                      rsp_err,
  input  logic                      flags_clr,
  output logic [ALU_FLAG_COUNT-1:0] status_flags,
  output logic [CNT_WIDTH-1:0]      op_count
);

  alu_seq_state_t r_state, w_state_nxt;

  logic [7:0]                r_op;
  logic [BUS_SIZE-1:0]       r_a;
  logic [BUS_SIZE-1:0]       r_b;
  logic                      r_setflags;
  logic                      r_carry_in;
  logic [BUS_SIZE-1:0]       r_rsp_res;
  logic [ALU_FLAG_COUNT-1:0] r_rsp_flags;
  logic                      r_rsp_err;
  logic [ALU_FLAG_COUNT-1:0] r_status_flags;
  logic [CNT_WIDTH-1:0]      r_op_count;

  logic                      w_req_ready;
  logic                      w_rsp_valid;
  logic                      w_accept;
  logic                      w_capture;
  logic                      w_rsp_hs;
  logic                      w_err;
  logic [BUS_SIZE-1:0]       w_alu_res;
  logic [ALU_FLAG_COUNT-1:0] w_alu_flags;

  alu_sequencer_alu #(.BUS_SIZE(BUS_SIZE)) u_alu (
    .i_op       (r_op),
    .i_a        (r_a),
    .i_b        (r_b),
    .i_carry_in (r_carry_in),
    .o_res      (w_alu_res),
    .o_flags    (w_alu_flags)
  );

  always_comb begin
    case (r_op)
      ALU_ADD, ALU_EQ, ALU_SUB, ALU_OR, ALU_AND, ALU_XOR, ALU_NEG: w_err = 1'b0;
      default: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ALU_SEQ_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ALU_SEQ_IDLE: begin
        w_req_ready = 1'b1;
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ALU_SEQ_EXEC;
        end
      end
      ALU_SEQ_EXEC: begin
        w_capture   = 1'b1;
        w_state_nxt = ALU_SEQ_RESP;
      end
      ALU_SEQ_RESP: begin
        w_rsp_valid = 1'b1;
        w_req_ready = rsp_ready;
        if (rsp_ready) begin
          if (req_valid) begin
            w_accept    = 1'b1;
            w_state_nxt = ALU_SEQ_EXEC;
          end else begin
            w_state_nxt = ALU_SEQ_IDLE;
          end
        end
      end
      default: w_state_nxt = ALU_SEQ_IDLE;
    endcase
  end

  assign w_rsp_hs = w_rsp_valid & rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op           <= '0;
      r_a            <= '0;
      r_b            <= '0;
      r_setflags     <= 1'b0;
      r_carry_in     <= 1'b0;
      r_rsp_res      <= '0;
      r_rsp_flags    <= '0;
      r_rsp_err      <= 1'b0;
      r_status_flags <= '0;
      r_op_count     <= '0;
    end else begin
      if (w_accept) begin
        r_op       <= req_op;
        r_a        <= req_a;
        r_b        <= req_b;
        r_setflags <= req_setflags;
        r_carry_in <= req_usecarry & r_status_flags[ALU_FLAG_OVERFLOW];
      end
      if (w_capture) begin
        r_rsp_res   <= w_alu_res;
        r_rsp_flags <= w_alu_flags;
        r_rsp_err   <= w_err;
      end
      // Clear takes priority over a capture landing on the same edge.
      if (flags_clr) begin
        r_status_flags <= '0;
      end else if (w_capture && r_setflags && !w_err) begin
        r_status_flags <= w_alu_flags;
      end
      if (w_rsp_hs) begin
        r_op_count <= r_op_count + CNT_WIDTH'(1);
      end
    end
  end

  // Gated so every output reads 0 while reset is held.
  assign req_ready    = w_req_ready & rst_n;
  assign rsp_valid    = w_rsp_valid;
  assign rsp_res      = r_rsp_res;
  assign rsp_flags    = r_rsp_flags;
  assign rsp_err      = r_rsp_err;
  assign status_flags = r_status_flags;
  assign op_count     = r_op_count;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer; a narrow-counter instance covers op_count wrap.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [7:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        req_setflags, req_usecarry;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_res;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
  logic        flags_clr;
  logic [3:0]  status_flags;
  logic [15:0] op_count;

  logic        w_rst_n, w_req_valid, w_req_ready, w_rsp_valid, w_rsp_ready, w_rsp_err;
  logic [31:0] w_rsp_res;
  logic [3:0]  w_rsp_flags, w_status_flags;
  logic [7:0]  w_op_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_cnt;

  alu_sequencer #(.BUS_SIZE(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_setflags(req_setflags),
    .req_usecarry(req_usecarry), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res), .rsp_flags(rsp_flags), .rsp_err(rsp_err), .flags_clr(flags_clr),
    .status_flags(status_flags), .op_count(op_count)
  );

  alu_sequencer #(.BUS_SIZE(32), .CNT_WIDTH(8)) dut_wrap (
    .clk(clk), .rst_n(w_rst_n), .req_valid(w_req_valid), .req_ready(w_req_ready),
    .req_op(ALU_ADD), .req_a(32'd1), .req_b(32'd2), .req_setflags(1'b0),
    .req_usecarry(1'b0), .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready),
    .rsp_res(w_rsp_res), .rsp_flags(w_rsp_flags), .rsp_err(w_rsp_err), .flags_clr(1'b0),
    .status_flags(w_status_flags), .op_count(w_op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction with rsp_ready held high; starts and ends one step after an edge.
  task automatic do_op(input string tag, input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic sf, input logic uc,
                       input logic [31:0] e_res, input logic [3:0] e_flags, input logic e_err);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    req_setflags = sf; req_usecarry = uc;
    chk({tag, " ready idle"}, req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk({tag, " valid exec"}, rsp_valid, 0);
    tick();
    chk({tag, " valid resp"}, rsp_valid, 1);
    chk({tag, " res"}, rsp_res, e_res);
    chk({tag, " flags"}, rsp_flags, e_flags);
    chk({tag, " err"}, rsp_err, e_err);
    tick();
    exp_cnt = exp_cnt + 16'd1;
    chk({tag, " count"}, op_count, exp_cnt);
    chk({tag, " valid after"}, rsp_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = 8'h00; req_a = '0; req_b = '0;
    req_setflags = 1'b0; req_usecarry = 1'b0; rsp_ready = 1'b1; flags_clr = 1'b0;
    w_rst_n = 1'b0; w_req_valid = 1'b0; w_rsp_ready = 1'b0;
    exp_cnt = '0;
    #12;
    chk("rst req_ready", req_ready, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_res", rsp_res, 0);
    chk("rst status", status_flags, 0);
    chk("rst count", op_count, 0);
    rst_n = 1'b1;
    tick();

    do_op("add", ALU_ADD, 32'd5, 32'd7, 1'b0, 1'b0, 32'd12, 4'b0000, 1'b0);
    do_op("sub", ALU_SUB, 32'd3, 32'd3, 1'b1, 1'b0, 32'd0, 4'b1001, 1'b0);
    chk("sub status", status_flags, 4'b1001);
    do_op("xor", ALU_XOR, 32'd1, 32'd0, 1'b0, 1'b0, 32'd1, 4'b0000, 1'b0);
    chk("xor status", status_flags, 4'b1001);
    do_op("addc", ALU_ADD, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 32'd0, 4'b0011, 1'b0);
    chk("addc status", status_flags, 4'b0011);
    do_op("cin", ALU_ADD, 32'd2, 32'd3, 1'b0, 1'b1, 32'd6, 4'b0000, 1'b0);
    do_op("neg", ALU_NEG, 32'd1, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 4'b0100, 1'b0);
    do_op("ill", 8'hFF, 32'd9, 32'd9, 1'b1, 1'b0, 32'd0, 4'b1001, 1'b1);
    chk("ill status", status_flags, 4'b0011);

    rsp_ready = 1'b0;
    req_valid = 1'b1; req_op = ALU_ADD; req_a = 32'd10; req_b = 32'd20;
    req_setflags = 1'b0; req_usecarry = 1'b0;
    tick();
    req_op = ALU_SUB; req_a = 32'd50; req_b = 32'd8;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp valid", rsp_valid, 1);
      chk("bp res", rsp_res, 32'd30);
      chk("bp ready", req_ready, 0);
      tick();
    end
    chk("bp count", op_count, exp_cnt);
    rsp_ready = 1'b1;
    #1;
    chk("b2b ready", req_ready, 1);
    tick();
    exp_cnt = exp_cnt + 16'd1;
    req_valid = 1'b0;
    chk("b2b count", op_count, exp_cnt);
    chk("b2b exec", rsp_valid, 0);
    tick();
    chk("b2b valid", rsp_valid, 1);
    chk("b2b res", rsp_res, 32'd42);
    tick();
    exp_cnt = exp_cnt + 16'd1;
    chk("b2b count2", op_count, exp_cnt);

    req_valid = 1'b1; req_op = ALU_SUB; req_a = 32'd5; req_b = 32'd5;
    req_setflags = 1'b1; req_usecarry = 1'b0;
    tick();
    req_valid = 1'b0;
    flags_clr = 1'b1;
    tick();
    flags_clr = 1'b0;
    chk("clr status", status_flags, 0);
    chk("clr rsp_flags", rsp_flags, 4'b1001);
    tick();

    req_valid = 1'b1; req_op = ALU_ADD; req_a = 32'd1; req_b = 32'd1;
    req_setflags = 1'b1;
    tick();
    req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst req_ready", req_ready, 0);
    chk("arst rsp_valid", rsp_valid, 0);
    chk("arst res", rsp_res, 0);
    chk("arst count", op_count, 0);
    chk("arst status", status_flags, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("arst no rsp", rsp_valid, 0);
    end

    tick();
    w_rst_n = 1'b1; w_req_valid = 1'b1; w_rsp_ready = 1'b1;
    repeat (511) @(posedge clk);
    #1;
    chk("wrap ff", w_op_count, 8'hFF);
    tick();
    chk("wrap hold", w_op_count, 8'hFF);
    tick();
    chk("wrap zero", w_op_count, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
